dpi_stream_sequencer: RTL
=========================

# dpi_stream_sequencer

Drives the per-stream regex matcher bank from the ingress byte stream: accepts packet bytes tagged with a 6-bit stream ID, restores matcher context, streams characters, then closes the packet so each matcher can commit its count and save state. It generates, in the required order and spacing, the `load_state`, `new_stream_id`, `enable`, `char_in`/`char_in_vld` and `eop` strobes the matcher instances consume. It keeps the 64-entry stream-seen table and the per-stream enable table.

## Interface
- `LOAD_GAP`, 2: idle cycles between the `load_state` pulse and the first `char_in_vld`; legal range 2..7.
- `EOP_GAP`, 2: cycles from the last `char_in_vld` to the `eop` pulse; legal range 1..7.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `in_vld` in 1: ingress byte valid.
- `in_rdy` out 1: ingress ready; a beat transfers when `in_vld & in_rdy`.
- `in_data` in 8: ingress byte.
- `in_sop` in 1: first byte of packet.
- `in_eop` in 1: last byte of packet.
- `in_stream_id` in 6: stream ID; sampled only on the SOP beat.
- `cfg_wr` in 1: write the per-stream enable bit.
- `cfg_stream_id` in 6: enable-table address.
- `cfg_enable` in 1: enable-table write data.
- `cfg_clear_seen` in 1: clear the whole stream-seen table.
- `load_state` out 1: one-cycle context-restore pulse.
- `new_stream_id` out 1: stream not seen since reset or clear; valid with `load_state`.
- `stream_id` out 6: current stream; stable from `load_state` through `eop`.
- `enable` out 1: enable-table bit for `stream_id`; stable from `load_state` through `eop`.
- `char_in` out 8: character to matchers.
- `char_in_vld` out 1: character valid.
- `eop` out 1: one-cycle end-of-packet commit pulse.
- `err_orphan` out 1: one-cycle pulse when a non-SOP beat is dropped in IDLE.
- `err_trunc` out 1: one-cycle pulse when SOP arrives mid-packet.
- `pkt_count` out 32: packet counter; statistics feature, see Configuration.
- `byte_count` out 32: byte counter; statistics feature, see Configuration.

## Operation
- **State machine:** IDLE, LOAD, GAP, STREAM, DRAIN, EOP.
- **IDLE**
  - `in_rdy`=1.
  - SOP beat: capture `in_stream_id` and `in_data` into a hold register; set `last` = `in_eop`; go to LOAD.
  - Non-SOP beat: consume it, pulse `err_orphan`, stay in IDLE.
- **LOAD**
  - `in_rdy`=0.
  - Assert `load_state` for one cycle.
  - `new_stream_id` = !seen[id]; `enable` = en_tbl[id], latched here.
  - Go to GAP.
- **GAP**
  - `in_rdy`=0.
  - Count `LOAD_GAP`-1 further cycles, then emit the held SOP byte on `char_in`/`char_in_vld`.
  - If `last`, go to DRAIN; otherwise go to STREAM.
- **STREAM**
  - `in_rdy`=1.
  - Each accepted beat is registered to `char_in`/`char_in_vld` with 1-cycle latency.
  - `in_vld`=0 gives a `char_in_vld`=0 bubble.
  - On the `in_eop` beat: `in_rdy` drops the next cycle; go to DRAIN.
  - On an `in_sop` beat: do not accept it (`in_rdy` is combinationally 0 when `in_sop`); pulse `err_trunc`; go to DRAIN. The SOP beat is taken later from IDLE.
- **DRAIN**
  - Wait until `EOP_GAP` cycles after the last `char_in_vld`, then go to EOP.
- **EOP**
  - Pulse `eop` for one cycle.
  - Set seen[`stream_id`]=1.
  - Go to IDLE.
- **Config writes**
  - `cfg_wr` updates en_tbl in the same cycle, whatever the state.
  - The `enable` output does not change within a packet; the new value applies from the next LOAD.
- **cfg_clear_seen**
  - Clears all seen bits. If asserted in the same cycle as EOP, the EOP set of the current stream's bit wins.
- **Back-to-back packets**
  - A minimum of one IDLE cycle separates `eop` and the next `load_state`.

## Timing
- **Reset values:** all outputs 0, state IDLE, seen table all 0, en_tbl all 0. `pkt_count` and `byte_count` reset to 0.
- **Reset mid-packet:** abandons the packet immediately. No `eop` is emitted and the seen bit is not set.
- **Single-byte packet** (SOP=EOP), with SOP accepted at cycle T:
  - `load_state` at T+1.
  - `char_in_vld` at T+1+`LOAD_GAP`.
  - `eop` at T+1+`LOAD_GAP`+`EOP_GAP`.
- **Streaming:** byte accepted at cycle t appears on `char_in` at t+1.
- **Throughput:** 1 byte/cycle in STREAM.

## Configuration
- `DPI_SEQ_STATS_EN` defined:
  - `pkt_count` increments by 1 on each `eop`.
  - `byte_count` increments by 1 on each `char_in_vld`.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- `DPI_SEQ_STATS_EN` undefined: both outputs are tied to 0 and no counter logic is built.

## Test plan
- **New stream:** reset; write en_tbl[5]=1; send a 4-byte packet on stream 5 ("abcd").
  - `load_state`=1 with `new_stream_id`=1, `enable`=1, `stream_id`=5.
  - 4 `char_in_vld` beats carrying a,b,c,d, then `eop`.
  - With stats: `pkt_count`=1, `byte_count`=4.
- **Known stream:** repeat the packet on stream 5 → `new_stream_id`=0. Then assert `cfg_clear_seen` and repeat → `new_stream_id`=1.
- **Single-byte packet** on stream 63 with defaults, SOP at cycle T → `load_state` at T+1, `char_in_vld` at T+3, `eop` at T+5.
- **Truncated packet:** SOP on stream 2, 2 bytes, then SOP on stream 3 without EOP.
  - `err_trunc` pulses once.
  - `eop` for stream 2.
  - Then `load_state` for stream 3, and its first byte is delivered.
- **Orphan beat and config write:**
  - Non-SOP beat in IDLE → `err_orphan` pulses and no `load_state` follows.
  - `cfg_wr` en_tbl[5]=0 in mid-packet on stream 5 → `enable` stays 1 until `eop`; the next packet shows `enable`=0.
- **Flow control:** `in_vld` bubbles during STREAM → matching `char_in_vld` gaps, byte order preserved. Reset asserted mid-packet → no `eop`, and the next packet on that stream has `new_stream_id`=1.

Source files
------------

// File: rtl/dpi_stream_sequencer.sv
`timescale 1ns/1ps
// dpi_stream_sequencer
//
// Sequences the ingress byte stream into the per-stream regex matcher bank.
// Each packet runs: context restore (load_state), LOAD_GAP spacing, one
// character per cycle, EOP_GAP drain, then a one-cycle eop commit pulse.
// Owns the 64-entry stream-seen table and the 64-entry per-stream enable table.
//
// Parameters
//   LOAD_GAP  cycles from load_state to the first char_in_vld (2..7)
//   EOP_GAP   cycles from the last char_in_vld to eop (1..7)
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   in_vld/in_rdy/in_data          ingress byte handshake
//   in_sop/in_eop/in_stream_id     packet framing; stream ID taken on SOP
//   cfg_wr/cfg_stream_id/cfg_enable  enable-table write port
//   cfg_clear_seen                 clear the whole stream-seen table
//   load_state/new_stream_id       context-restore pulse, first-use flag
//   stream_id/enable               current stream and its latched enable
//   char_in/char_in_vld            character stream to the matchers
//   eop                            end-of-packet commit pulse
//   err_orphan/err_trunc           dropped non-SOP beat / SOP mid-packet
//   pkt_count/byte_count           statistics counters
//
// Build option
//   DPI_SEQ_STATS_EN  when defined, pkt_count and byte_count are live
//                     wrapping 32-bit counters; otherwise tied to 0.
module dpi_stream_sequencer #(
    parameter int LOAD_GAP = 2,
    parameter int EOP_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_vld,
    output logic        in_rdy,
    input  logic [7:0]  in_data,
    input  logic        in_sop,
    input  logic        in_eop,
    input  logic [5:0]  in_stream_id,
    input  logic        cfg_wr,
    input  logic [5:0]  cfg_stream_id,
    input  logic        cfg_enable,
    input  logic        cfg_clear_seen,
    output logic        load_state,
    output logic        new_stream_id,
    output logic [5:0]  stream_id,
    output logic        enable,
    output logic [7:0]  char_in,
    output logic        char_in_vld,
    output logic        eop,
    output logic        err_orphan,
    output logic        err_trunc,
    output logic [31:0] pkt_count,
    output logic [31:0] byte_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_GAP, S_STREAM, S_DRAIN, S_EOP
    } state_t;

    // GAP lasts LOAD_GAP-1 cycles; the counter starts at 0 on GAP entry.
    localparam logic [2:0] GAP_LAST   = 3'(LOAD_GAP - 2);
    // DRAIN leaves once EOP_GAP-1 cycles have passed since the last character.
    localparam logic [2:0] DRAIN_LAST = 3'(EOP_GAP - 1);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        last_q, last_d;
    logic [5:0]  stream_id_q, stream_id_d;
    logic        enable_q, enable_d;
    logic [7:0]  char_q, char_d;
    logic        char_vld_q, char_vld_d;
    logic        err_orphan_q, err_orphan_d;
    logic        err_trunc_q, err_trunc_d;
    logic [63:0] seen_q, seen_d;
    logic [63:0] en_tbl_q, en_tbl_d;

    always_comb begin
        state_d      = state_q;
        hold_data_d  = hold_data_q;
        last_d       = last_q;
        stream_id_d  = stream_id_q;
        enable_d     = enable_q;
        char_d       = char_q;
        char_vld_d   = 1'b0;
        err_orphan_d = 1'b0;
        err_trunc_d  = 1'b0;
        in_rdy       = 1'b0;
        load_state   = 1'b0;
        eop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    if (in_sop) begin
                        stream_id_d = in_stream_id;
                        hold_data_d = in_data;
                        last_d      = in_eop;
                        state_d     = S_LOAD;
                    end else begin
                        err_orphan_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                load_state = 1'b1;
                enable_d   = en_tbl_q[stream_id_q];
                state_d    = S_GAP;
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    char_vld_d = 1'b1;
                    char_d     = hold_data_q;
                    state_d    = last_q ? S_DRAIN : S_STREAM;
                end
            end
            S_STREAM: begin
                // A new SOP is refused here and picked up again from IDLE.
                in_rdy = !in_sop;
                if (in_vld) begin
                    if (in_sop) begin
                        err_trunc_d = 1'b1;
                        state_d     = S_DRAIN;
                    end else begin
                        char_vld_d = 1'b1;
                        char_d     = in_data;
                        if (in_eop) begin
                            state_d = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q >= DRAIN_LAST) begin
                    state_d = S_EOP;
                end
            end
            S_EOP: begin
                eop     = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // One counter serves both gaps: it restarts on LOAD, then counts cycles
    // since the most recent character (saturating, enough for EOP_GAP <= 7).
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_LOAD || char_vld_d) begin
            cnt_d = 3'd0;
        end else if (cnt_q != 3'd7) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Per-entry table updates. The seen bit set by eop takes priority over a
    // simultaneous clear so the stream that just committed stays known.
    genvar gi;
    generate
        for (gi = 0; gi < 64; gi = gi + 1) begin : g_tbl
            assign en_tbl_d[gi] = (cfg_wr && (cfg_stream_id == 6'(gi))) ?
                                  cfg_enable : en_tbl_q[gi];
            assign seen_d[gi]   = (eop && (stream_id_q == 6'(gi))) ? 1'b1 :
                                  (cfg_clear_seen ? 1'b0 : seen_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            hold_data_q  <= 8'd0;
            last_q       <= 1'b0;
            stream_id_q  <= 6'd0;
            enable_q     <= 1'b0;
            char_q       <= 8'd0;
            char_vld_q   <= 1'b0;
            err_orphan_q <= 1'b0;
            err_trunc_q  <= 1'b0;
            seen_q       <= 64'd0;
            en_tbl_q     <= 64'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hold_data_q  <= hold_data_d;
            last_q       <= last_d;
            stream_id_q  <= stream_id_d;
            enable_q     <= enable_d;
            char_q       <= char_d;
            char_vld_q   <= char_vld_d;
            err_orphan_q <= err_orphan_d;
            err_trunc_q  <= err_trunc_d;
            seen_q       <= seen_d;
            en_tbl_q     <= en_tbl_d;
        end
    end

    assign new_stream_id = load_state & ~seen_q[stream_id_q];
    assign stream_id     = stream_id_q;
    // During LOAD the table is presented directly so enable is valid with
    // load_state; from then on the latched copy holds it for the packet.
    assign enable        = (state_q == S_LOAD) ? en_tbl_q[stream_id_q] : enable_q;
    assign char_in       = char_q;
    assign char_in_vld   = char_vld_q;
    assign err_orphan    = err_orphan_q;
    assign err_trunc     = err_trunc_q;

`ifdef DPI_SEQ_STATS_EN
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [31:0] byte_count_q, byte_count_d;

    always_comb begin
        pkt_count_d  = (state_q == S_EOP) ? pkt_count_q + 32'd1 : pkt_count_q;
        byte_count_d = char_vld_q ? byte_count_q + 32'd1 : byte_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_count_q  <= 32'd0;
            byte_count_q <= 32'd0;
        end else begin
            pkt_count_q  <= pkt_count_d;
            byte_count_q <= byte_count_d;
        end
    end

    assign pkt_count  = pkt_count_q;
    assign byte_count = byte_count_q;
`else
    assign pkt_count  = 32'd0;
    assign byte_count = 32'd0;
`endif

endmodule
